// File: rtl/derot_pkg.sv
// rtl/derot_pkg.sv - shared widths and limits for the cyclic derotator
//
// Purpose: data, offset and counter widths plus the word counter ceiling,
//          imported by every file of the derotator.
// Ports:   none (package).
package derot_pkg;

    localparam int DATA_W = 4;
    localparam int OFF_W  = 2;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/derot_shift4.sv
// rtl/derot_shift4.sv - combinational variable right rotation of a 4-bit word
//
// Purpose: rotate data right by amt bit positions (bit i of rotated is
//          bit (i+amt) mod 4 of data).
// Ports:   data    [3:0] word to rotate
//          amt     [1:0] rotation amount
//          rotated [3:0] rotated word
module derot_shift4
    import derot_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  amt,
    output logic [DATA_W-1:0] rotated
);

    always_comb begin
        rotated = data;
        case (amt)
            2'd1:    rotated = {data[0],   data[3:1]};
            2'd2:    rotated = {data[1:0], data[3:2]};
            2'd3:    rotated = {data[2:0], data[3]};
            default: rotated = data;
        endcase
    end

endmodule

// File: rtl/cyclic_derotator4.sv
// rtl/cyclic_derotator4.sv - undoes a transmitter's per-word cyclic rotation
//
// Purpose: tracks the transmitter's accumulated rotation offset (left steps,
//          mod 4) and rotates each accepted word right by the updated offset,
//          presenting it through a single-entry output register with
//          pass-through backpressure.
// Optional feature: macro DEROT_WORD_CNT_EN adds the word_cnt port, a
//          saturating count of delivered words.
// Ports:   clk, rst               clock, asynchronous active-high reset
//          in_valid/in_ready      input handshake
//          in_data [3:0]          rotated word
//          in_en, in_rot_dir      one rotation step applied, 1 = left
//          clr_offset             synchronous clear of the offset
//          out_valid/out_ready    output handshake
//          out_data [3:0]         restored word
//          offset [1:0]           registered accumulated offset
//          word_cnt [7:0]         delivered word count (DEROT_WORD_CNT_EN)
module cyclic_derotator4
    import derot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_en,
    input  logic              in_rot_dir,
    input  logic              clr_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OFF_W-1:0]  offset
`ifdef DEROT_WORD_CNT_EN
    ,
    output logic [CNT_W-1:0]  word_cnt
`endif
);

    logic              accept;
    logic [OFF_W-1:0]  base;
    logic [OFF_W-1:0]  off_n;
    logic [DATA_W-1:0] rotated;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // The clear takes effect before this word's step, so a cleared word
    // with a step lands on offset 1 (left) or 3 (right).
    always_comb begin
        base  = clr_offset ? '0 : offset;
        off_n = base;
        if (in_en) begin
            off_n = in_rot_dir ? base + 2'd1 : base + 2'd3;
        end
    end

    derot_shift4 u_shift (
        .data    (in_data),
        .amt     (off_n),
        .rotated (rotated)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            offset    <= '0;
`ifdef DEROT_WORD_CNT_EN
            word_cnt  <= '0;
`endif
        end else begin
            if (accept) begin
                offset    <= off_n;
                out_data  <= rotated;
                out_valid <= 1'b1;
            end else begin
                if (clr_offset) begin
                    offset <= '0;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
`ifdef DEROT_WORD_CNT_EN
            if (out_valid && out_ready && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_cyclic_derotator4.sv
// tb/tb_cyclic_derotator4.sv - self-checking bench for cyclic_derotator4
module tb_cyclic_derotator4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       in_en = 1'b0;
    logic       in_rot_dir = 1'b0;
    logic       clr_offset = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic [1:0] offset;
`ifdef DEROT_WORD_CNT_EN
    logic [7:0] word_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_valid = 0;
    int m_data  = 0;
    int m_off   = 0;
    int m_cnt   = 0;
    int sb[$];

    cyclic_derotator4 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_en      (in_en),
        .in_rot_dir (in_rot_dir),
        .clr_offset (clr_offset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .offset     (offset)
`ifdef DEROT_WORD_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // restored bit i is transmitted bit (i+k) mod 4
    function automatic int rotr(input int d, input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((d >> ((i + k) % 4)) & 1) != 0) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("out_valid", int'(out_valid), m_valid);
        check("offset", int'(offset), m_off);
        if (m_valid != 0) check("out_data", int'(out_data), m_data);
`ifdef DEROT_WORD_CNT_EN
        check("word_cnt", int'(word_cnt), m_cnt);
`endif
    endtask

    // Called at a falling edge; applies one cycle of inputs and advances the model.
    task automatic step(input bit v, input int d, input bit en, input bit dir,
                        input bit clr, input bit r);
        bit acc;
        int base;
        int noff;
        in_valid   = v;
        in_data    = 4'(d);
        in_en      = en;
        in_rot_dir = dir;
        clr_offset = clr;
        out_ready  = r;
        #1;
        check("in_ready", int'(in_ready), (m_valid == 0 || r) ? 1 : 0);
        if (m_valid != 0 && r) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("delivered", int'(out_data), sb.pop_front());
            end
            if (m_cnt < 255) m_cnt++;
        end
        acc  = v && (m_valid == 0 || r);
        base = clr ? 0 : m_off;
        noff = en ? (dir ? (base + 1) % 4 : (base + 3) % 4) : base;
        if (acc) begin
            m_off   = noff;
            m_data  = rotr(d, noff);
            m_valid = 1;
            sb.push_back(m_data);
        end else begin
            if (clr) m_off = 0;
            if (m_valid != 0 && r) m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // Asserts reset between edges, checks cleared state, releases at a falling edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_offset", int'(offset), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef DEROT_WORD_CNT_EN
        check("rst_word_cnt", int'(word_cnt), 0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 0;
        m_data  = 0;
        m_off   = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    int held_data;
    int held_off;

    initial begin
        @(negedge clk);
        do_reset();

        // left steps, wrap upward
        step(1, 4'b0010, 1, 1, 0, 1);
        check("d1_data", int'(out_data), 4'b0001);
        check("d1_off", int'(offset), 1);
        step(1, 4'b0100, 1, 1, 0, 1);
        check("d2_data", int'(out_data), 4'b0001);
        check("d2_off", int'(offset), 2);
        step(1, 4'b1000, 1, 1, 0, 1);
        check("d3_data", int'(out_data), 4'b0001);
        step(1, 4'b0001, 1, 1, 0, 1);
        check("d4_data", int'(out_data), 4'b0001);
        check("d4_off", int'(offset), 0);

        // right step from 0 wraps to 3
        step(1, 4'b1000, 1, 0, 0, 1);
        check("d5_data", int'(out_data), 4'b0001);
        check("d5_off", int'(offset), 3);

        // stall: held word and offset must not move, steps ignored
        step(1, 4'b0110, 1, 1, 0, 0);
        held_data = int'(out_data);
        held_off  = int'(offset);
        for (int i = 0; i < 3; i++) begin
            step(1, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 0, 0);
            check("stall_ready", int'(in_ready), 0);
            check("stall_data", int'(out_data), held_data);
            check("stall_off", int'(offset), held_off);
        end
        step(1, 4'b0011, 1, 1, 0, 1);
        check("resume_valid", int'(out_valid), 1);
        check("resume_off", int'(offset), (held_off + 1) % 4);
        step(0, 0, 0, 0, 0, 1);
        check("drain_valid", int'(out_valid), 0);
        check("sb_empty", sb.size(), 0);

        // clear applied before the step
        step(1, 4'b0001, 1, 1, 1, 1);
        step(1, 4'b0010, 1, 1, 0, 1);
        check("pre_clr_off", int'(offset), 2);
        step(1, 4'b0010, 1, 1, 1, 1);
        check("clr_off", int'(offset), 1);
        check("clr_data", int'(out_data), 4'b0001);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0));
        end

`ifdef DEROT_WORD_CNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), 1);
        end
        check("cnt_sat", int'(word_cnt), 255);
`else
        for (int i = 0; i < 20; i++) begin
            step(1, int'($urandom_range(0, 15)), 1, 1, 0, 1);
        end
`endif
        // mid-stream reset with a word held
        check("pre_rst_valid", int'(out_valid), 1);
        do_reset();
        step(0, 0, 0, 0, 0, 1);
        check("post_rst_valid", int'(out_valid), 0);
        check("post_rst_off", int'(offset), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
